sdram_cmd_timing_gate: RTL and testbench

Command-timing enforcement stage between the SDRAM command arbiter and the SDRAM PHY command driver. Accepts one SDRAM command per cycle over valid/ready. Holds each command until every JEDEC inter-command delay that applies to it has elapsed, then forwards it through one output register. All delays use one global timing model (not per bank) and are tracked with loadable down-counters.

---
 rtl/sdram_cmd_pkg.sv | 25 ++
 rtl/sdram_tmr_down.sv | 16 +
 rtl/sdram_cmd_timing_gate.sv | 74 +++++++
 tb/tb_sdram_cmd_timing_gate.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: command codes, field widths and timing-counter indices for the SDRAM command path
package sdram_cmd_pkg;
  localparam int CMD_W  = 3;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 15;
  localparam int TMR_W  = 8;
  localparam int N_TMR  = 7;
  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6,
    CMD_RSV = 3'd7
  } cmd_e;
  localparam int I_RCD = 0;
  localparam int I_RP  = 1;
  localparam int I_RC  = 2;
  localparam int I_RAS = 3;
  localparam int I_WR  = 4;
  localparam int I_RFC = 5;
  localparam int I_MRD = 6;
endpackage

// File: rtl/sdram_tmr_down.sv
// sdram_tmr_down: loadable down-counter saturating at 0, with zero flag
import sdram_cmd_pkg::*;
module sdram_tmr_down (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = (cnt == '0);
endmodule

// File: rtl/sdram_cmd_timing_gate.sv
// sdram_cmd_timing_gate: holds each SDRAM command until its inter-command delays expire, then registers it to the PHY
import sdram_cmd_pkg::*;
module sdram_cmd_timing_gate #(
  parameter int T_RCD = 2,
  parameter int T_RP  = 2,
  parameter int T_RC  = 7,
  parameter int T_RAS = 5,
  parameter int T_WR  = 2,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_cmd_valid,
  output logic              s_cmd_ready,
  input  logic [CMD_W-1:0]  s_cmd,
  input  logic [BA_W-1:0]   s_ba,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              m_cmd_valid,
  output logic [CMD_W-1:0]  m_cmd,
  output logic [BA_W-1:0]   m_ba,
  output logic [ADDR_W-1:0] m_addr,
  output logic              busy
);
  if (T_RCD < 1 || T_RCD > 256 || T_RP < 1 || T_RP > 256 || T_RC < 1 || T_RC > 256 ||
      T_RAS < 1 || T_RAS > 256 || T_WR < 1 || T_WR > 256 || T_RFC < 1 || T_RFC > 256 ||
      T_MRD < 1 || T_MRD > 256) begin : g_bad_timing
    $error("sdram_cmd_timing_gate: every T_* must lie in 1..256");
  end
  localparam logic [TMR_W-1:0] LV [N_TMR] = '{TMR_W'(T_RCD - 1), TMR_W'(T_RP - 1),
    TMR_W'(T_RC - 1), TMR_W'(T_RAS - 1), TMR_W'(T_WR - 1), TMR_W'(T_RFC - 1), TMR_W'(T_MRD - 1)};
  logic [N_TMR-1:0] ld, z;
  logic acc, cas_ok, act_ok, pre_ok, mrs_ok, fwd;
  genvar i;
  for (i = 0; i < N_TMR; i++) begin : g_tmr
    sdram_tmr_down u_tmr (.clk, .rst_n, .load(ld[i]), .load_val(LV[i]), .zero(z[i]));
  end
  assign cas_ok = z[I_RCD] & z[I_RFC] & z[I_MRD];
  assign act_ok = z[I_RP] & z[I_RC] & z[I_RFC] & z[I_MRD];
  assign pre_ok = z[I_RAS] & z[I_WR] & z[I_RFC] & z[I_MRD];
  assign mrs_ok = z[I_RP] & z[I_RFC] & z[I_MRD];
  always_comb
    s_cmd_ready = (s_cmd == CMD_RD || s_cmd == CMD_WR)  ? cas_ok :
                  (s_cmd == CMD_ACT || s_cmd == CMD_REF) ? act_ok :
                  (s_cmd == CMD_PRE)                     ? pre_ok :
                  (s_cmd == CMD_MRS)                     ? mrs_ok : 1'b1;
  assign acc = s_cmd_valid & s_cmd_ready;
  assign fwd = acc && s_cmd != CMD_NOP && s_cmd != CMD_RSV;
  always_comb begin
    ld        = '0;
    ld[I_RCD] = acc && s_cmd == CMD_ACT;
    ld[I_RC]  = acc && s_cmd == CMD_ACT;
    ld[I_RAS] = acc && s_cmd == CMD_ACT;
    ld[I_RP]  = acc && s_cmd == CMD_PRE;
    ld[I_WR]  = acc && s_cmd == CMD_WR;
    ld[I_RFC] = acc && s_cmd == CMD_REF;
    ld[I_MRD] = acc && s_cmd == CMD_MRS;
  end
  assign busy = ~&z;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_cmd_valid <= 1'b0;
      m_cmd       <= CMD_NOP;
      m_ba        <= '0;
      m_addr      <= '0;
    end else begin
      m_cmd_valid <= fwd;
      m_cmd       <= fwd ? s_cmd : CMD_NOP;
      if (fwd) begin
        m_ba   <= s_ba;
        m_addr <= s_addr;
      end
    end
endmodule

// File: tb/tb_sdram_cmd_timing_gate.sv
// tb_sdram_cmd_timing_gate: directed vector table plus multi-cycle spacing and reset sequences
import sdram_cmd_pkg::*;
module tb_sdram_cmd_timing_gate;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_cmd_valid = 1'b0;
  logic [2:0] s_cmd = 3'd0;
  logic [1:0] s_ba = 2'd0;
  logic [14:0] s_addr = 15'd0;
  logic rdy, mv, bsy, rdy1, mv1, bsy1;
  logic [2:0] mc, mc1;
  logic [1:0] mba, mba1;
  logic [14:0] ma, ma1;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_cmd_timing_gate u_dut (.clk(clk), .rst_n(rst_n), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(rdy),
    .s_cmd(s_cmd), .s_ba(s_ba), .s_addr(s_addr), .m_cmd_valid(mv), .m_cmd(mc), .m_ba(mba),
    .m_addr(ma), .busy(bsy));
  sdram_cmd_timing_gate #(.T_RCD(1), .T_RP(1), .T_RC(1), .T_RAS(1), .T_WR(1), .T_RFC(1), .T_MRD(1))
    u_one (.clk(clk), .rst_n(rst_n), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(rdy1),
    .s_cmd(s_cmd), .s_ba(s_ba), .s_addr(s_addr), .m_cmd_valid(mv1), .m_cmd(mc1), .m_ba(mba1),
    .m_addr(ma1), .busy(bsy1));

  typedef struct {
    logic v; logic [2:0] c; logic [1:0] ba; logic [14:0] a;
    logic rdy; logic mv; logic [2:0] mc; logic busy; logic [1:0] mba; logic [14:0] ma;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [1:0] b, input logic [14:0] a);
    s_cmd_valid = v; s_cmd = c; s_ba = b; s_addr = a;
  endtask

  task automatic do_reset();
    drive(1'b0, CMD_NOP, 2'd0, 15'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] c, input logic [1:0] b, input logic [14:0] a,
                      input bit chk_busy, output int acc);
    int n = 0;
    drive(1'b1, c, b, a);
    #1;
    while (!rdy && n < 50) begin
      if (chk_busy) chk("busy_gap", bsy, 1);
      @(negedge clk); #1;
      n++;
    end
    if (!rdy) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
      drive(1'b0, CMD_NOP, 2'd0, 15'd0);
    end else begin
      acc = cyc;
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, CMD_NOP, 2'd0, 15'd0);
      #1;
      chk("send_mvalid", mv, 1);
      chk("send_mcmd", mc, c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1;
    logic [2:0] seq [9];
    logic [2:0] pc;
    tbl[0] = '{1'b1, CMD_ACT, 2'd1, 15'h0123, 1'b1, 1'b0, CMD_NOP, 1'b0, 2'd0, 15'h0000};
    tbl[1] = '{1'b1, CMD_RD,  2'd1, 15'h0040, 1'b0, 1'b1, CMD_ACT, 1'b1, 2'd1, 15'h0123};
    tbl[2] = '{1'b1, CMD_RD,  2'd1, 15'h0040, 1'b1, 1'b0, CMD_NOP, 1'b1, 2'd1, 15'h0123};
    tbl[3] = '{1'b1, CMD_PRE, 2'd2, 15'h0400, 1'b0, 1'b1, CMD_RD,  1'b1, 2'd1, 15'h0040};
    tbl[4] = '{1'b1, CMD_PRE, 2'd2, 15'h0400, 1'b0, 1'b0, CMD_NOP, 1'b1, 2'd1, 15'h0040};
    tbl[5] = '{1'b1, CMD_PRE, 2'd2, 15'h0400, 1'b1, 1'b0, CMD_NOP, 1'b1, 2'd1, 15'h0040};
    tbl[6] = '{1'b1, CMD_ACT, 2'd3, 15'h7fff, 1'b0, 1'b1, CMD_PRE, 1'b1, 2'd2, 15'h0400};
    tbl[7] = '{1'b1, CMD_ACT, 2'd3, 15'h7fff, 1'b1, 1'b0, CMD_NOP, 1'b0, 2'd2, 15'h0400};
    tbl[8] = '{1'b0, CMD_NOP, 2'd0, 15'h0000, 1'b1, 1'b1, CMD_ACT, 1'b1, 2'd3, 15'h7fff};
    seq = '{CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_ACT, CMD_NOP, CMD_RD};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 3'(k), 2'd0, 15'd0);
      #1;
      chk("reset_ready", rdy, 1);
    end
    chk("reset_busy", bsy, 0);
    chk("reset_mvalid", mv, 0);

    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].v, tbl[k].c, tbl[k].ba, tbl[k].a);
      #1;
      chk($sformatf("tbl%0d_ready", k), rdy, tbl[k].rdy);
      chk($sformatf("tbl%0d_mvalid", k), mv, tbl[k].mv);
      chk($sformatf("tbl%0d_mcmd", k), mc, tbl[k].mc);
      chk($sformatf("tbl%0d_busy", k), bsy, tbl[k].busy);
      chk($sformatf("tbl%0d_mba", k), mba, tbl[k].mba);
      chk($sformatf("tbl%0d_maddr", k), ma, tbl[k].ma);
      @(negedge clk); #1;
    end

    do_reset();
    send(CMD_REF, 2'd0, 15'd0, 1'b0, a0);
    send(CMD_ACT, 2'd1, 15'h0011, 1'b1, a1);
    chk("gap_rfc", a1 - a0, 7);

    do_reset();
    send(CMD_ACT, 2'd0, 15'h0022, 1'b0, a0);
    send(CMD_PRE, 2'd0, 15'h0000, 1'b0, a1);
    chk("gap_ras", a1 - a0, 5);

    do_reset();
    send(CMD_ACT, 2'd1, 15'h0033, 1'b0, a0);
    idle(10);
    send(CMD_WR, 2'd1, 15'h0008, 1'b0, a0);
    send(CMD_PRE, 2'd1, 15'h0000, 1'b0, a1);
    chk("gap_wr", a1 - a0, 2);

    do_reset();
    pc = CMD_NOP;
    for (int k = 0; k < 10; k++) begin
      drive(k < 9, k < 9 ? seq[k] : CMD_NOP, 2'(k), 15'(k));
      #1;
      chk($sformatf("one%0d_ready", k), rdy1, 1);
      chk($sformatf("one%0d_mvalid", k), mv1, k > 0 && pc != CMD_NOP);
      chk($sformatf("one%0d_mcmd", k), mc1, pc);
      chk($sformatf("one%0d_busy", k), bsy1, 0);
      pc = k < 9 ? seq[k] : CMD_NOP;
      @(negedge clk); #1;
    end

    do_reset();
    send(CMD_REF, 2'd0, 15'd0, 1'b0, a0);
    idle(2);
    chk("pre_reset_busy", bsy, 1);
    rst_n = 1'b0;
    #1;
    chk("in_reset_mvalid", mv, 0);
    chk("in_reset_busy", bsy, 0);
    idle(1);
    chk("in_reset_busy_hold", bsy, 0);
    chk("in_reset_mcmd", mc, CMD_NOP);
    rst_n = 1'b1;
    drive(1'b1, CMD_ACT, 2'd2, 15'h0abc);
    #1;
    chk("post_reset_ready", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, CMD_NOP, 2'd0, 15'd0);
    #1;
    chk("post_reset_mvalid", mv, 1);
    chk("post_reset_mcmd", mc, CMD_ACT);
    chk("post_reset_maddr", ma, 15'h0abc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
